serial_parity_checker: RTL

// - Receiving end of the parity-protected 4-bit link; the multi-input XOR parity generator is the sending end.
// - Deserialises DATA_W data bits plus one parity bit, then recomputes parity over the data bits.
// - Presents the parallel word with a pass/fail flag and a saturating error count.
// - Sits between the serial link pins and the consumer logic; one clock domain.
//

---
 rtl/parity_pkg.sv | 14 +
 rtl/sipo_shift_reg.sv | 29 ++
 rtl/serial_parity_checker.sv | 104 ++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity receiver.
//   par_state_t : receiver FSM state (collecting data bits / awaiting parity bit)
//   EVEN / ODD  : parity sense selectors
package parity_pkg;

    typedef enum logic {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } par_state_t;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in / parallel-out shift register.
// Bits arrive LSB first and enter at the MSB end, shifting right, so after
// W loads the first bit received sits at q[0].
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (q -> 0)
//   clr  : synchronous clear (q -> 0)
//   load : shift din in this cycle
//   din  : serial input bit
//   q    : parallel word
module sipo_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (load) begin
            q <= {din, q[W-1:1]};
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Receiving end of the parity-protected serial link. Collects DATA_W data
// bits (LSB first) followed by one parity bit, recomputes parity and reports
// the word with a pass/fail flag and a saturating error count.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   clr       : synchronous frame abort (drops any partial frame)
//   in_valid  : in_bit is sampled this cycle
//   in_bit    : serial bit
//   out_valid : one-cycle pulse, frame complete
//   out_data  : received word, held until the next frame completes
//   par_err   : parity mismatch flag, held with out_data
//   err_count : number of frames with par_err=1, saturating
//   busy      : a partial frame is held
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int ODD_PAR = 0,
    parameter int ERR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              par_err,
    output logic [ERR_W-1:0]  err_count,
    output logic              busy
);

    localparam int                CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
    localparam logic              PAR_SENSE = (ODD_PAR != 0) ? ODD : EVEN;

    par_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic              acc;
    logic [DATA_W-1:0] sr_q;
    logic              accept_data;
    logic              err;

    // clr has priority over a coincident in_valid, so the bit is not shifted.
    assign accept_data = in_valid && !clr && (state == S_DATA);

    // Parity over data and parity bit must equal the selected sense.
    assign err = acc ^ in_bit ^ PAR_SENSE;

    assign busy = (bit_cnt != '0);

    sipo_shift_reg #(.W(DATA_W)) u_sipo (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .load (accept_data),
        .din  (in_bit),
        .q    (sr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_DATA;
            bit_cnt   <= '0;
            acc       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            par_err   <= 1'b0;
            err_count <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                state   <= S_DATA;
                bit_cnt <= '0;
                acc     <= 1'b0;
            end else if (in_valid) begin
                case (state)
                    S_DATA: begin
                        acc <= acc ^ in_bit;
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_PAR;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_PAR: begin
                        out_valid <= 1'b1;
                        out_data  <= sr_q;
                        par_err   <= err;
                        if (err && (err_count != ERR_MAX)) begin
                            err_count <= err_count + 1'b1;
                        end
                        acc     <= 1'b0;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                    default: state <= S_DATA;
                endcase
            end
        end
    end

endmodule
